mdu_iter: RTL and testbench

- Parametrised iterative multiply/divide unit. Companion to the combinational ALU in the EX stage.
- Holds architectural HI/LO and executes MULT/MULTU/DIV/DIVU over multiple cycles, one bit per cycle.
- Also executes single-cycle MTHI/MTLO writes.
- The pipeline stalls on busy before issuing MFHI/MFLO or another MDU op; MFHI/MFLO are plain reads of the hi/lo ports.

---
 rtl/mdu_iter.sv | 164 ++++++++++++++++
 tb/tb_mdu_iter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit holding HI/LO. One shift-add / shift-subtract step per cycle.
// Defining MDU_MADD_EN adds MADD/MADDU/MSUB/MSUBU (accumulate into {hi,lo}).
module mdu_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] pr_q, pr_d;     // mult: {partial, multiplier}; div: {rem, quotient}
    logic [WIDTH-1:0]   dvs_q, dvs_d;   // multiplicand / divisor magnitude
    logic               div_q, div_d, neg_q, neg_d, rneg_q, rneg_d, dz_q, dz_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               done_q, done_d, err_q, err_d;
`ifdef MDU_MADD_EN
    logic               mac_q, mac_d, sub_q, sub_d;
`endif

    logic               is_mul, is_div, is_sgn, is_mt, is_valid;
    logic [WIDTH-1:0]   a_mag, b_mag, quo, rem;
    logic [WIDTH:0]     mul_sum, div_tmp, div_diff;
    logic [2*WIDTH-1:0] step, prod;

    always_comb begin
        is_mul = (op == 4'd0) || (op == 4'd1);
        is_div = (op == 4'd2) || (op == 4'd3);
        is_sgn = (op == 4'd0) || (op == 4'd2);
        is_mt  = (op == 4'd4) || (op == 4'd5);
`ifdef MDU_MADD_EN
        if (op >= 4'd6 && op <= 4'd9) is_mul = 1'b1;
        if (op == 4'd6 || op == 4'd8) is_sgn = 1'b1;
`endif
        is_valid = is_mul || is_div || is_mt;
        a_mag = (is_sgn && a[WIDTH-1]) ? -a : a;
        b_mag = (is_sgn && b[WIDTH-1]) ? -b : b;

        mul_sum  = {1'b0, pr_q[2*WIDTH-1:WIDTH]} + (pr_q[0] ? {1'b0, dvs_q} : {(WIDTH+1){1'b0}});
        div_tmp  = {pr_q[2*WIDTH-1:WIDTH], pr_q[WIDTH-1]};
        div_diff = div_tmp - {1'b0, dvs_q};
        if (div_q)
            step = div_diff[WIDTH] ? {div_tmp[WIDTH-1:0], pr_q[WIDTH-2:0], 1'b0}
                                   : {div_diff[WIDTH-1:0], pr_q[WIDTH-2:0], 1'b1};
        else
            step = {mul_sum, pr_q[WIDTH-1:1]};

        prod = neg_q ? -step : step;
`ifdef MDU_MADD_EN
        if (mac_q) prod = sub_q ? ({hi_q, lo_q} - prod) : ({hi_q, lo_q} + prod);
`endif
        // Restoring division by zero naturally leaves rem = |a|; only the quotient needs forcing.
        quo = dz_q ? {WIDTH{1'b1}} : (neg_q ? -step[WIDTH-1:0] : step[WIDTH-1:0]);
        rem = rneg_q ? -step[2*WIDTH-1:WIDTH] : step[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pr_d    = pr_q;
        dvs_d   = dvs_q;
        div_d   = div_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        dz_d    = dz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
`ifdef MDU_MADD_EN
        mac_d   = mac_q;
        sub_d   = sub_q;
`endif
        if (state_q == IDLE) begin
            if (start && is_mt) begin
                if (op == 4'd4) hi_d = a;
                else            lo_d = a;
            end else if (start && (is_mul || is_div)) begin
                state_d = RUN;
                cnt_d   = CNT_W'(WIDTH);
                pr_d    = {{WIDTH{1'b0}}, a_mag};
                dvs_d   = b_mag;
                div_d   = is_div;
                neg_d   = is_sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
                rneg_d  = is_sgn && is_div && a[WIDTH-1];
                dz_d    = (b == {WIDTH{1'b0}});
`ifdef MDU_MADD_EN
                mac_d   = (op >= 4'd6);
                sub_d   = (op == 4'd8) || (op == 4'd9);
`endif
            end
        end else begin
            err_d = start && is_valid;
            pr_d  = step;
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                state_d = IDLE;
                done_d  = 1'b1;
                if (div_q) begin
                    hi_d = rem;
                    lo_d = quo;
                end else begin
                    {hi_d, lo_d} = prod;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pr_q    <= '0;
            dvs_q   <= '0;
            div_q   <= 1'b0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef MDU_MADD_EN
            mac_q   <= 1'b0;
            sub_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pr_q    <= pr_d;
            dvs_q   <= dvs_d;
            div_q   <= div_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            dz_q    <= dz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            err_q   <= err_d;
`ifdef MDU_MADD_EN
            mac_q   <= mac_d;
            sub_q   <= sub_d;
`endif
        end
    end

    assign busy = (state_q == RUN);
    assign done = done_q;
    assign err  = err_q;
    assign hi   = hi_q;
    assign lo   = lo_q;
endmodule

// File: tb/tb_mdu_iter.sv
// Scoreboarded random + directed bench for mdu_iter (WIDTH=32) against an arithmetic reference model.
module tb_mdu_iter;
    localparam int W = 32;

    logic         clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [3:0]   op = '0;
    logic [W-1:0] a = '0, b = '0;
    logic         busy, done, err;
    logic [W-1:0] hi, lo;

    mdu_iter #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .err(err), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    int             total = 0, bad = 0, done_cnt = 0, push_cnt = 0;
    logic [2*W-1:0] expq[$];
    logic [2*W-1:0] mon_e;
    logic [W-1:0]   mhi = '0, mlo = '0;
    longint         cyc = 0, busy_end = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding result.
    always @(negedge clk) begin
        if (rst_n && done === 1'b1) begin
            done_cnt++;
            if (expq.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_done: got hi=%h lo=%h want no result", hi, lo);
            end else begin
                mon_e = expq.pop_front();
                chk("result", {hi, lo}, mon_e);
                chk("busy_at_done", 64'(busy), 64'(0));
            end
        end
    end

    function automatic logic [63:0] mul_model(input logic [3:0] o, input logic [W-1:0] x,
                                              input logic [W-1:0] y, input logic [63:0] cur);
        longint     sx, sy;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (o == 4'd0 || o == 4'd6 || o == 4'd8) p = 64'(sx * sy);
        else p = {32'b0, x} * {32'b0, y};
        if (o == 4'd6 || o == 4'd7) p = cur + p;
        if (o == 4'd8 || o == 4'd9) p = cur - p;
        return p;
    endfunction

    function automatic logic [63:0] div_model(input logic [3:0] o, input logic [W-1:0] x,
                                              input logic [W-1:0] y);
        int         sx, sy;
        logic [W-1:0] q, r;
        if (y == 0) begin
            q = '1; r = x;
        end else if (o == 4'd2) begin
            if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                q = 32'h8000_0000; r = '0;
            end else begin
                sx = x; sy = y;
                q = sx / sy; r = sx % sy;
            end
        end else begin
            q = x / y; r = x % y;
        end
        return {r, q};
    endfunction

    // Issue one request at a negedge; the model decides acceptance from the cycle count.
    task automatic drive(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         output bit iter);
        bit          valid, acc;
        logic [63:0] r;
        valid = (o <= 4'd5);
`ifdef MDU_MADD_EN
        valid = (o <= 4'd9);
`endif
        acc  = (cyc + 1 > busy_end);
        iter = 1'b0;
        r    = '0;
        start = 1'b1; op = o; a = x; b = y;
        if (valid && acc) begin
            case (o)
                4'd4: mhi = x;
                4'd5: mlo = x;
                4'd2, 4'd3: begin r = div_model(o, x, y); iter = 1'b1; end
                default: begin r = mul_model(o, x, y, {mhi, mlo}); iter = 1'b1; end
            endcase
        end
        if (iter) begin
            expq.push_back(r);
            push_cnt++;
            busy_end = cyc + 1 + W;
            {mhi, mlo} = r;
        end
        @(negedge clk);
        start = 1'b0;
        chk("err", 64'(err), 64'(valid && !acc));
        if (iter) chk("busy_start", 64'(busy), 64'(1));
        else if (acc) begin
            chk("busy_idle", 64'(busy), 64'(0));
            chk("hilo_idle", {hi, lo}, {mhi, mlo});
        end
    endtask

    // Count busy cycles from the negedge after acceptance; ends on the done negedge.
    task automatic finish_op(input string nm);
        int n = 0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk({nm, "_busy_cycles"}, 64'(n), 64'(W));
        chk({nm, "_done"}, 64'(done), 64'(1));
    endtask

    task automatic run(input string nm, input logic [3:0] o, input logic [W-1:0] x,
                       input logic [W-1:0] y);
        bit it;
        drive(o, x, y, it);
        if (it) begin
            finish_op(nm);
            @(negedge clk);
            chk({nm, "_done_pulse"}, 64'(done), 64'(0));
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (busy !== 1'b0) chk("wait_idle_timeout", 64'(busy), 64'(0));
        @(negedge clk);
    endtask

    function automatic logic [W-1:0] rnd();
        case ($urandom_range(0, 7))
            0: return '0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h1;
            4: return 32'($urandom_range(0, 20)) - 32'd10;
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit it;
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_err", 64'(err), 64'(0));
        chk("rst_hilo", {hi, lo}, 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset mid-MULT
        run("mthi", 4'd4, 32'hAAAA, 0);
        run("mtlo", 4'd5, 32'h5555, 0);
        drive(4'd0, 32'd5, 32'd6, it);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_hilo", {hi, lo}, 64'(0));
        chk("abort_busy", 64'(busy), 64'(0));
        void'(expq.pop_back());
        push_cnt--;
        mhi = '0; mlo = '0; busy_end = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed arithmetic cases
        run("multu", 4'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("multu_dir", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        run("mult", 4'd0, -32'sd7, 32'd3);
        chk("mult_dir", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        run("div", 4'd2, -32'sd7, 32'd2);
        chk("div_dir", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run("divu0", 4'd3, 32'd100, 32'd0);
        chk("divu0_dir", {hi, lo}, 64'h0000_0064_FFFF_FFFF);
        run("divovf", 4'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("divovf_dir", {hi, lo}, 64'h0000_0000_8000_0000);
        run("divs0", 4'd2, -32'sd5, 32'd0);

        // Collisions while busy
        drive(4'd0, 32'd1000, -32'sd3, it);
        drive(4'd4, 32'h1234, 0, it);
        drive(4'd0, 32'd9, 32'd9, it);
        wait_idle();
        chk("collide_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_F448);
        run("mthi_idle", 4'd4, 32'h1234, 0);
        chk("mthi_dir", 64'(hi), 64'h1234);

        // Back-to-back: second DIVU issued on the done cycle
        drive(4'd3, 32'd1000, 32'd7, it);
        finish_op("b2b1");
        drive(4'd3, 32'hDEAD_BEEF, 32'd16, it);
        chk("b2b_accept", 64'(it), 64'(1));
        finish_op("b2b2");
        @(negedge clk);
        chk("b2b_dir", {hi, lo}, 64'h0000_000F_0DEA_DBEE);

        // Accumulate sequence (no-op without the feature)
        run("z_hi", 4'd4, 32'd0, 0);
        run("f_lo", 4'd5, 32'hFFFF_FFFF, 0);
        run("maddu", 4'd7, 32'd1, 32'd1);
`ifdef MDU_MADD_EN
        chk("maddu_dir", {hi, lo}, 64'h0000_0001_0000_0000);
`else
        chk("maddu_dir", {hi, lo}, 64'h0000_0000_FFFF_FFFF);
`endif
        run("msubu", 4'd9, 32'd1, 32'd1);
        chk("msubu_dir", {hi, lo}, 64'h0000_0000_FFFF_FFFF);

        // Random ops including no-op codes
        for (int i = 0; i < 60; i++) begin
            run("rnd", 4'($urandom_range(0, 15)), rnd(), rnd());
        end

        repeat (3) @(negedge clk);
        chk("queue_empty", 64'(expq.size()), 64'(0));
        chk("done_count", 64'(done_cnt), 64'(push_cnt));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
